wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline write-back path and
//  the long-latency multiply/divide unit (MDU). Pipeline writes get priority; MDU results queue in
//  a small buffer, and the stage asks the pipeline to stall when an MDU result has waited too long.

---
 rtl/wb_port_arbiter_pkg.sv | 25 ++
 rtl/wb_result_fifo.sv | 108 ++++++++++
 rtl/wb_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the write-back port arbiter and its MDU result buffer.
package wb_port_arbiter_pkg;

   localparam int XLEN_DEF       = 64;
   localparam int REG_ADDR_W     = 5;
   localparam int DEPTH_DEF      = 2;
   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_MDU  = 2'd2
   } grant_e;

   typedef enum logic {
      ARB_RUN   = 1'b0,
      ARB_STALL = 1'b1
   } arb_state_e;

   // x0 is hardwired to zero, so any write aimed at it is discarded.
   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
      return (rd == {REG_ADDR_W{1'b0}});
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of MDU results. Each entry carries a live bit that a write-after-write
// kill port can clear by destination register; dead entries still occupy a slot until popped.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [REG_ADDR_W-1:0]   push_rd,
   input  logic [XLEN-1:0]         push_data,
   input  logic                    pop,
   input  logic                    kill,
   input  logic [REG_ADDR_W-1:0]   kill_rd,
   output logic                    head_valid,
   output logic                    head_live,
   output logic [REG_ADDR_W-1:0]   head_rd,
   output logic [XLEN-1:0]         head_data,
   output logic                    full,
   output logic                    empty_next,
   output logic [$clog2(DEPTH):0]  live_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W:0]        occ_r;
   logic [PTR_W:0]        occ_next_s;
   logic [DEPTH-1:0]      valid_r;
   logic [DEPTH-1:0]      live_r;
   logic [REG_ADDR_W-1:0] rd_mem_r   [DEPTH];
   logic [XLEN-1:0]       data_mem_r [DEPTH];

   assign head_valid = (occ_r != {(PTR_W+1){1'b0}});
   assign head_live  = live_r[rd_ptr_r];
   assign head_rd    = rd_mem_r[rd_ptr_r];
   assign head_data  = data_mem_r[rd_ptr_r];
   assign full       = (occ_r == OCC_FULL);
   assign empty_next = (occ_next_s == {(PTR_W+1){1'b0}});

   // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      occ_next_s = occ_r;
      if (push && !pop) begin
         occ_next_s = occ_r + OCC_ONE;
      end else if (!push && pop) begin
         occ_next_s = occ_r - OCC_ONE;
      end else begin
         occ_next_s = occ_r;
      end
   end

   // Population count of live entries.
   always_comb begin
      live_count = {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         live_count = live_count + {{PTR_W{1'b0}}, live_r[i]};
      end
   end

   // Entry storage, pointers and per-entry live/valid state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {(PTR_W+1){1'b0}};
         valid_r  <= {DEPTH{1'b0}};
         live_r   <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_r[i]   <= {REG_ADDR_W{1'b0}};
            data_mem_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill && valid_r[i] && (rd_mem_r[i] == kill_rd)) begin
               live_r[i] <= 1'b0;
            end else begin
               live_r[i] <= live_r[i];
            end
         end
         // Pop and push touch different slots whenever both fire, so later writes win safely.
         if (pop) begin
            valid_r[rd_ptr_r] <= 1'b0;
            live_r[rd_ptr_r]  <= 1'b0;
            rd_ptr_r          <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (push) begin
            valid_r[wr_ptr_r]    <= 1'b1;
            live_r[wr_ptr_r]     <= 1'b1;
            rd_mem_r[wr_ptr_r]   <= push_rd;
            data_mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r             <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         occ_r <= occ_next_s;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB stage and buffered MDU results,
// with pipeline priority, WAW kill of stale MDU results and a starvation-driven stall.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pipe_we_i,
   input  logic [REG_ADDR_W-1:0]   pipe_rd_i,
   input  logic [XLEN-1:0]         pipe_data_i,
   input  logic                    mdu_valid_i,
   output logic                    mdu_ready_o,
   input  logic [REG_ADDR_W-1:0]   mdu_rd_i,
   input  logic [XLEN-1:0]         mdu_data_i,
   output logic                    rf_we_o,
   output logic [REG_ADDR_W-1:0]   rf_rd_o,
   output logic [XLEN-1:0]         rf_data_o,
   output logic                    stall_o,
   output logic [$clog2(DEPTH):0]  pending_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   arb_state_e            state_r;
   logic [CNT_W-1:0]      starve_cnt_r;
   logic [CNT_W-1:0]      cnt_inc_s;
   grant_e                grant_s;
   logic                  pipe_req_s;
   logic                  push_hs_s;
   logic                  store_s;
   logic                  pop_s;
   logic                  head_valid_s;
   logic                  head_live_s;
   logic [REG_ADDR_W-1:0] head_rd_s;
   logic [XLEN-1:0]       head_data_s;
   logic                  full_s;
   logic                  empty_next_s;

   assign pipe_req_s  = pipe_we_i && !is_x0(pipe_rd_i);
   assign mdu_ready_o = reset && !full_s;
   assign push_hs_s   = mdu_valid_i && mdu_ready_o;
   // A result racing a granted pipe write to the same register is already stale.
   assign store_s     = push_hs_s && !is_x0(mdu_rd_i)
                        && !((grant_s == GNT_PIPE) && (mdu_rd_i == pipe_rd_i));
   assign pop_s       = head_valid_s && ((grant_s == GNT_MDU) || !head_live_s);
   assign stall_o     = (state_r == ARB_STALL);

   wb_result_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (store_s),
      .push_rd    (mdu_rd_i),
      .push_data  (mdu_data_i),
      .pop        (pop_s),
      .kill       (grant_s == GNT_PIPE),
      .kill_rd    (pipe_rd_i),
      .head_valid (head_valid_s),
      .head_live  (head_live_s),
      .head_rd    (head_rd_s),
      .head_data  (head_data_s),
      .full       (full_s),
      .empty_next (empty_next_s),
      .live_count (pending_o)
   );

   // Port grant: a stall cycle belongs to the buffer head, otherwise the pipeline wins.
   always_comb begin
      grant_s = GNT_NONE;
      if (state_r == ARB_STALL) begin
         if (head_live_s) begin
            grant_s = GNT_MDU;
         end else begin
            grant_s = GNT_NONE;
         end
      end else if (pipe_req_s) begin
         grant_s = GNT_PIPE;
      end else if (head_live_s) begin
         grant_s = GNT_MDU;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   // Saturating increment of the starvation counter.
   always_comb begin
      if (starve_cnt_r == CNT_MAX) begin
         cnt_inc_s = CNT_MAX;
      end else begin
         cnt_inc_s = starve_cnt_r + CNT_ONE;
      end
   end

   // Stall FSM, starvation counter and the registered write port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ARB_RUN;
         starve_cnt_r <= {CNT_W{1'b0}};
         rf_we_o      <= 1'b0;
         rf_rd_o      <= {REG_ADDR_W{1'b0}};
         rf_data_o    <= {XLEN{1'b0}};
      end else begin
         rf_we_o <= (grant_s != GNT_NONE);
         case (grant_s)
            GNT_PIPE: begin
               rf_rd_o   <= pipe_rd_i;
               rf_data_o <= pipe_data_i;
            end
            GNT_MDU: begin
               rf_rd_o   <= head_rd_s;
               rf_data_o <= head_data_s;
            end
            default: begin
               rf_rd_o   <= rf_rd_o;
               rf_data_o <= rf_data_o;
            end
         endcase
         case (state_r)
            ARB_STALL: begin
               state_r      <= ARB_RUN;
               starve_cnt_r <= {CNT_W{1'b0}};
            end
            ARB_RUN: begin
               if ((grant_s == GNT_MDU) || empty_next_s) begin
                  state_r      <= ARB_RUN;
                  starve_cnt_r <= {CNT_W{1'b0}};
               end else if (head_live_s) begin
                  starve_cnt_r <= cnt_inc_s;
                  if (cnt_inc_s == CNT_MAX) begin
                     state_r <= ARB_STALL;
                  end else begin
                     state_r <= ARB_RUN;
                  end
               end else begin
                  state_r      <= ARB_RUN;
                  starve_cnt_r <= starve_cnt_r;
               end
            end
            default: begin
               state_r      <= ARB_RUN;
               starve_cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued as stimulus
// is driven and compared in order whenever the DUT asserts rf_we_o.
module tb_wb_port_arbiter;

   logic        clk;
   logic        reset;
   logic        pipe_we_i;
   logic [4:0]  pipe_rd_i;
   logic [63:0] pipe_data_i;
   logic        mdu_valid_i;
   logic        mdu_ready_o;
   logic [4:0]  mdu_rd_i;
   logic [63:0] mdu_data_i;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [63:0] rf_data_o;
   logic        stall_o;
   logic [1:0]  pending_o;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mdu_model[$];
   wr_t mon_e;
   int  total  = 0;
   int  passed = 0;

   wb_port_arbiter #(
      .XLEN       (64),
      .DEPTH      (2),
      .STARVE_MAX (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pipe_we_i   (pipe_we_i),
      .pipe_rd_i   (pipe_rd_i),
      .pipe_data_i (pipe_data_i),
      .mdu_valid_i (mdu_valid_i),
      .mdu_ready_o (mdu_ready_o),
      .mdu_rd_i    (mdu_rd_i),
      .mdu_data_i  (mdu_data_i),
      .rf_we_o     (rf_we_o),
      .rf_rd_o     (rf_rd_o),
      .rf_data_o   (rf_data_o),
      .stall_o     (stall_o),
      .pending_o   (pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every write the DUT issues must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rf_we_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_write: got rd=%0d data=%h, expected no write", rf_rd_o, rf_data_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (rf_rd_o !== mon_e.rd || rf_data_o !== mon_e.data)
                  $display("FAIL sb_write: got rd=%0d data=%h, want rd=%0d data=%h",
                           rf_rd_o, rf_data_o, mon_e.rd, mon_e.data);
               else passed++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      pipe_we_i   = 1'b0;
      pipe_rd_i   = 5'd0;
      pipe_data_i = 64'h0;
      mdu_valid_i = 1'b0;
      mdu_rd_i    = 5'd0;
      mdu_data_i  = 64'h0;
   endtask

   // One pipeline cycle; while stalled the oldest buffered MDU result takes the port instead.
   task automatic pipe_step(input logic [4:0] rd, input logic [63:0] data,
                            output logic consumed, output logic stalled);
      stalled     = stall_o;
      pipe_we_i   = 1'b1;
      pipe_rd_i   = rd;
      pipe_data_i = data;
      if (stalled === 1'b1) begin
         consumed = 1'b0;
         if (mdu_model.size() != 0) exp_q.push_back(mdu_model.pop_front());
         else begin
            total++;
            $display("FAIL stall_empty: got stall_o=1, want no stall with empty buffer");
         end
      end else begin
         consumed = 1'b1;
         exp_q.push_back('{rd: rd, data: data});
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_idle();
      repeat (3) tick();
      total++; if (rf_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", rf_we_o); else passed++;
      total++; if (rf_rd_o !== 5'd0 || rf_data_o !== 64'h0)
         $display("FAIL reset_rd_data: got %0d/%h want 0/0", rf_rd_o, rf_data_o); else passed++;
      total++; if (stall_o !== 1'b0 || pending_o !== 2'd0)
         $display("FAIL reset_stall_pend: got %b/%0d want 0/0", stall_o, pending_o); else passed++;
      total++; if (mdu_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", mdu_ready_o); else passed++;
      reset = 1'b1;
      #1;
      total++; if (mdu_ready_o !== 1'b1) $display("FAIL release_ready: got %b want 1", mdu_ready_o); else passed++;
      // Fill the buffer behind a busy pipeline, then reset mid-burst.
      pipe_we_i = 1'b1; pipe_rd_i = 5'd1; pipe_data_i = 64'h100;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd2; mdu_data_i = 64'h200;
      exp_q.push_back('{rd: 5'd1, data: 64'h100});
      tick();
      pipe_data_i = 64'h101; mdu_rd_i = 5'd4; mdu_data_i = 64'h400;
      exp_q.push_back('{rd: 5'd1, data: 64'h101});
      tick();
      total++; if (pending_o !== 2'd2 || mdu_ready_o !== 1'b0)
         $display("FAIL burst_full: got pend=%0d ready=%b want 2/0", pending_o, mdu_ready_o); else passed++;
      set_idle();
      reset = 1'b0;
      tick();
      total++; if (rf_we_o !== 1'b0 || pending_o !== 2'd0 || mdu_ready_o !== 1'b0)
         $display("FAIL midreset: got we=%b pend=%0d ready=%b want 0/0/0", rf_we_o, pending_o, mdu_ready_o);
      else passed++;
      reset = 1'b1;
      #1;
      total++; if (mdu_ready_o !== 1'b1) $display("FAIL midreset_release: got %b want 1", mdu_ready_o); else passed++;
      repeat (3) tick();
      total++; if (pending_o !== 2'd0) $display("FAIL lost_results: got pend=%0d want 0", pending_o); else passed++;
   endtask

   task automatic test_mdu_only();
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd5; mdu_data_i = 64'hA5;
      total++; if (mdu_ready_o !== 1'b1) $display("FAIL mdu_ready: got %b want 1", mdu_ready_o); else passed++;
      exp_q.push_back('{rd: 5'd5, data: 64'hA5});
      tick();
      mdu_valid_i = 1'b0;
      total++; if (rf_we_o !== 1'b0 || pending_o !== 2'd1)
         $display("FAIL mdu_t1: got we=%b pend=%0d want 0/1", rf_we_o, pending_o); else passed++;
      tick();
      total++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_data_o !== 64'hA5)
         $display("FAIL mdu_t2: got %b/%0d/%h want 1/5/a5", rf_we_o, rf_rd_o, rf_data_o); else passed++;
      tick();
      total++; if (rf_we_o !== 1'b0 || rf_rd_o !== 5'd5 || rf_data_o !== 64'hA5)
         $display("FAIL idle_hold: got %b/%0d/%h want 0/5/a5", rf_we_o, rf_rd_o, rf_data_o); else passed++;
   endtask

   task automatic test_pipe_priority();
      int first_stall = -1;
      int stalls = 0;
      int k = 0;
      logic c, s;
      for (int cyc = 0; cyc < 10; cyc++) begin
         mdu_valid_i = (cyc == 0); mdu_rd_i = 5'd7; mdu_data_i = 64'h77;
         if (mdu_valid_i && mdu_ready_o) mdu_model.push_back('{rd: 5'd7, data: 64'h77});
         pipe_step(5'd3, 64'h300 + 64'(k), c, s);
         if (c) k++;
         if (s === 1'b1) begin
            stalls++;
            if (first_stall < 0) first_stall = cyc;
         end
      end
      set_idle();
      tick();
      total++; if (first_stall !== 5) $display("FAIL prio_stall_cycle: got %0d want 5", first_stall); else passed++;
      total++; if (stalls !== 1) $display("FAIL prio_stall_count: got %0d want 1", stalls); else passed++;
      total++; if (stall_o !== 1'b0 || pending_o !== 2'd0)
         $display("FAIL prio_end: got stall=%b pend=%0d want 0/0", stall_o, pending_o); else passed++;
   endtask

   task automatic test_waw_kill();
      set_idle();
      pipe_we_i = 1'b1; pipe_rd_i = 5'd2; pipe_data_i = 64'h22;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd9; mdu_data_i = 64'h99;
      exp_q.push_back('{rd: 5'd2, data: 64'h22});
      tick();
      total++; if (pending_o !== 2'd1) $display("FAIL waw_buffered: got %0d want 1", pending_o); else passed++;
      mdu_valid_i = 1'b0; pipe_rd_i = 5'd9; pipe_data_i = 64'h11;
      exp_q.push_back('{rd: 5'd9, data: 64'h11});
      tick();
      total++; if (pending_o !== 2'd0) $display("FAIL waw_killed: got %0d want 0", pending_o); else passed++;
      set_idle();
      tick();
      total++; if (rf_we_o !== 1'b0) $display("FAIL waw_second_write: got %b want 0", rf_we_o); else passed++;
      // A dead head frees its slot alongside a pipe grant.
      pipe_we_i = 1'b1; pipe_rd_i = 5'd2; pipe_data_i = 64'h24;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd13; mdu_data_i = 64'hD1;
      exp_q.push_back('{rd: 5'd2, data: 64'h24});
      tick();
      pipe_rd_i = 5'd13; pipe_data_i = 64'h1D; mdu_rd_i = 5'd14; mdu_data_i = 64'hE1;
      exp_q.push_back('{rd: 5'd13, data: 64'h1D});
      tick();
      total++; if (pending_o !== 2'd1 || mdu_ready_o !== 1'b0)
         $display("FAIL dead_full: got pend=%0d ready=%b want 1/0", pending_o, mdu_ready_o); else passed++;
      mdu_valid_i = 1'b0; pipe_rd_i = 5'd2; pipe_data_i = 64'h25;
      exp_q.push_back('{rd: 5'd2, data: 64'h25});
      tick();
      total++; if (pending_o !== 2'd1 || mdu_ready_o !== 1'b1)
         $display("FAIL dead_pop: got pend=%0d ready=%b want 1/1", pending_o, mdu_ready_o); else passed++;
      set_idle();
      exp_q.push_back('{rd: 5'd14, data: 64'hE1});
      tick();
      // Same-cycle collision: the MDU result is accepted and dropped.
      pipe_we_i = 1'b1; pipe_rd_i = 5'd12; pipe_data_i = 64'h12;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd12; mdu_data_i = 64'hCC;
      total++; if (mdu_ready_o !== 1'b1) $display("FAIL collide_ready: got %b want 1", mdu_ready_o); else passed++;
      exp_q.push_back('{rd: 5'd12, data: 64'h12});
      tick();
      set_idle();
      total++; if (pending_o !== 2'd0) $display("FAIL collide_drop: got %0d want 0", pending_o); else passed++;
      tick();
      total++; if (rf_we_o !== 1'b0) $display("FAIL collide_write: got %b want 0", rf_we_o); else passed++;
   endtask

   task automatic test_full_buffer();
      int first_stall = -1;
      int stalls = 0;
      int accepted = -1;
      int k = 0;
      logic c, s;
      for (int cyc = 0; cyc < 18; cyc++) begin
         if (cyc < 2) begin
            mdu_valid_i = 1'b1; mdu_rd_i = 5'd20 + 5'(cyc); mdu_data_i = 64'h2000 + 64'(cyc);
         end else if (accepted < 0) begin
            mdu_valid_i = 1'b1; mdu_rd_i = 5'd22; mdu_data_i = 64'h2200;
         end else begin
            mdu_valid_i = 1'b0;
         end
         if (cyc == 2) begin
            total++; if (mdu_ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", mdu_ready_o); else passed++;
         end
         if (mdu_valid_i && mdu_ready_o) begin
            mdu_model.push_back('{rd: mdu_rd_i, data: mdu_data_i});
            if (cyc >= 2) accepted = cyc;
         end
         pipe_step(5'd1, 64'h1000 + 64'(k), c, s);
         if (c) k++;
         if (s === 1'b1) begin
            stalls++;
            if (first_stall < 0) first_stall = cyc;
         end
      end
      set_idle();
      while (mdu_model.size() != 0) exp_q.push_back(mdu_model.pop_front());
      repeat (3) tick();
      total++; if (first_stall !== 5) $display("FAIL full_first_stall: got %0d want 5", first_stall); else passed++;
      total++; if (accepted !== 6) $display("FAIL full_accept_cycle: got %0d want 6", accepted); else passed++;
      total++; if (stalls !== 3) $display("FAIL full_stall_count: got %0d want 3", stalls); else passed++;
   endtask

   task automatic test_x0();
      pipe_we_i = 1'b1; pipe_rd_i = 5'd0; pipe_data_i = 64'hDEAD;
      mdu_valid_i = 1'b1; mdu_rd_i = 5'd0; mdu_data_i = 64'hBEEF;
      total++; if (mdu_ready_o !== 1'b1) $display("FAIL x0_ready: got %b want 1", mdu_ready_o); else passed++;
      tick();
      total++; if (rf_we_o !== 1'b0 || pending_o !== 2'd0)
         $display("FAIL x0_nowrite: got we=%b pend=%0d want 0/0", rf_we_o, pending_o); else passed++;
      mdu_rd_i = 5'd6; mdu_data_i = 64'h66;
      exp_q.push_back('{rd: 5'd6, data: 64'h66});
      tick();
      mdu_valid_i = 1'b0;
      total++; if (pending_o !== 2'd1) $display("FAIL x0_buffered: got %0d want 1", pending_o); else passed++;
      tick();
      total++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd6)
         $display("FAIL x0_pipe_nonreq: got we=%b rd=%0d want 1/6", rf_we_o, rf_rd_o); else passed++;
      set_idle();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         mdu_valid_i = 1'b1; mdu_rd_i = 5'd1 + 5'(i); mdu_data_i = 64'hB0 + 64'(i);
         total++; if (mdu_ready_o !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, mdu_ready_o); else passed++;
         exp_q.push_back('{rd: mdu_rd_i, data: mdu_data_i});
         tick();
      end
      set_idle();
      total++; if (pending_o !== 2'd1) $display("FAIL b2b_pending: got %0d want 1", pending_o); else passed++;
      repeat (2) tick();
   endtask

   initial begin
      int n;
      reset = 1'b0;
      set_idle();
      test_reset();
      test_mdu_only();
      test_pipe_priority();
      test_waw_kill();
      test_full_buffer();
      test_x0();
      test_back_to_back();
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (exp_q.size() != 0) $display("FAIL drain: got %0d writes outstanding, want 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
